cache_switch_ctrl: RTL and testbench
====================================

Name: cache_switch_ctrl

Overview:
Sequencer directly downstream of the instruction decoder. Consumes the decoder's switch_cache_w strobe, issued for the custom opcode 7'b1111111. Freezes the pipeline, waits for the active cache to go idle, and has it flush dirty lines through a req/ack handshake. It then retargets the cache select to the new context's cache bank and releases the pipeline with a one-cycle completion pulse.

Parameters:
NUM_CACHES, 4, number of selectable cache banks (2..16)
SEL_W, 2, width of cache_sel; must satisfy 2**SEL_W >= NUM_CACHES

Ports:
CLK  in  1  core clock
RESET  in  1  synchronous, active-high reset
switch_cache_w  in  1  decoder strobe, high while a cache-switch instruction sits in the consuming stage
switch_id  in  SEL_W  target bank id (low bits of rs1 value), valid with switch_cache_w
cache_busy  in  1  active cache is servicing a miss or refill
flush_ack  in  1  cache reports flush complete (single-cycle pulse)
flush_req  out  1  request to flush/write back the active cache
stall  out  1  freeze PC and pipeline registers
cache_sel  out  SEL_W  currently selected cache bank
switch_done  out  1  one-cycle pulse when a switch completes (including skipped and error cases)
switch_err  out  1  one-cycle pulse, coincident with switch_done, when switch_id >= NUM_CACHES

Behaviour:
- One clock, CLK; reset is synchronous and active-high on RESET. All state updates on posedge CLK.
- Reset values: state=IDLE, cache_sel=0, flush_req=0, switch_done=0, switch_err=0, pending id=0. stall is 0 in IDLE with no request.
- RESET takes priority over everything. It aborts any in-flight switch at the next edge: flush_req drops and cache_sel returns to 0. A flush_ack arriving afterwards is ignored.
- States: IDLE, WAIT_IDLE, FLUSH, SWITCH, DONE.
- IDLE: when switch_cache_w=1, latch switch_id into pending and go to WAIT_IDLE. Otherwise stay in IDLE.
- WAIT_IDLE: hold while cache_busy=1. When cache_busy=0, select the next state:
  - pending >= NUM_CACHES: go to DONE with error flagged.
  - pending == cache_sel: go to DONE; no flush, no error.
  - otherwise: go to FLUSH.
- FLUSH: flush_req=1 (registered, asserted the whole time in FLUSH). On flush_ack=1, go to SWITCH. flush_req is low in the cycle after the ack.
- SWITCH: cache_sel <= pending at the edge leaving SWITCH. Go to DONE.
- DONE: switch_done=1; switch_err=1 only if the error was flagged. stall=0. Go to IDLE unconditionally. switch_cache_w is ignored in DONE so the still-present strobe cannot retrigger.
- stall is combinational: stall = (state != IDLE && state != DONE) || (state == IDLE && switch_cache_w). It is therefore high in the same cycle the strobe first appears.
- switch_cache_w and switch_id are sampled only in IDLE; changes in other states are ignored.
- flush_ack outside FLUSH is ignored.
- Minimum latency for a real switch (cache_busy=0, flush_ack in the first FLUSH cycle): stall high for 4 cycles (IDLE-req, WAIT_IDLE, FLUSH, SWITCH); switch_done in the 5th cycle. The new cache_sel is visible in the DONE cycle.
- Same-id or error path: stall high for 2 cycles; done in the 3rd.
- No limit on time spent in WAIT_IDLE or FLUSH in the base configuration.

Optional Feature:
CACHE_SWITCH_STATS_EN. When defined, add output switch_count [15:0]:
- reset to 0;
- increments in each DONE cycle that performed an actual bank change (SWITCH was visited);
- saturates at 16'hFFFF.
Same-id and error completions do not count. When undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: RESET=1 for 2 cycles -> cache_sel=0, flush_req=0, stall=0, switch_done=0.
- Basic switch: switch_cache_w=1 with switch_id=2, cache_busy=0, flush_ack pulsed on the first flush_req cycle -> stall high for 4 cycles, flush_req high for 1 cycle, cache_sel=2 and switch_done=1 in cycle 5, switch_err=0.
- Busy wait: cache_busy held high for 3 cycles after the request, switch_id=1 -> flush_req does not rise until cache_busy falls; stall is held throughout; final cache_sel=1.
- Same-id and error: with cache_sel=2, request id 2 -> no flush_req, done in cycle 3, cache_sel stays 2. Request id 5 with NUM_CACHES=4 -> switch_err=1 with switch_done, cache_sel unchanged.
- Reset mid-flush: RESET=1 while flush_req=1, then flush_ack pulsed -> state IDLE, cache_sel=0, no switch_done, stall=0.
- Strobe held through DONE: switch_cache_w kept high through DONE -> exactly one switch_done pulse, no re-entry into WAIT_IDLE. With CACHE_SWITCH_STATS_EN defined, switch_count increments by 1 per real switch only.

Source files
------------

// File: rtl/cache_switch_ctrl_if.sv
// Bus between the instruction decoder / active cache and the cache-switch sequencer.
// The slave modport is the sequencer; the master modport is its environment.
// Optional macro: CACHE_SWITCH_STATS_EN adds the switch_count statistics output.
interface cache_switch_ctrl_if #(
    parameter int SEL_W = 2
);
    logic             switch_cache_w;
    logic [SEL_W-1:0] switch_id;
    logic             cache_busy;
    logic             flush_ack;
    logic             flush_req;
    logic             stall;
    logic [SEL_W-1:0] cache_sel;
    logic             switch_done;
    logic             switch_err;
`ifdef CACHE_SWITCH_STATS_EN
    logic [15:0]      switch_count;
`endif

    modport master (
`ifdef CACHE_SWITCH_STATS_EN
        input  switch_count,
`endif
        output switch_cache_w,
        output switch_id,
        output cache_busy,
        output flush_ack,
        input  flush_req,
        input  stall,
        input  cache_sel,
        input  switch_done,
        input  switch_err
    );

    modport slave (
`ifdef CACHE_SWITCH_STATS_EN
        output switch_count,
`endif
        input  switch_cache_w,
        input  switch_id,
        input  cache_busy,
        input  flush_ack,
        output flush_req,
        output stall,
        output cache_sel,
        output switch_done,
        output switch_err
    );
endinterface

// File: rtl/cache_switch_ctrl.sv
// Cache-switch sequencer: freezes the pipeline on a switch instruction, waits for
// the active cache to go idle, flushes it, retargets cache_sel and pulses done.
// Optional macro: CACHE_SWITCH_STATS_EN adds a saturating 16-bit count of real switches.
module cache_switch_ctrl #(
    parameter int NUM_CACHES = 4,
    parameter int SEL_W      = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    cache_switch_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        FLUSH,
        SWITCH,
        DONE
    } state_t;

    // One extra bit so a bank count equal to 2**SEL_W is still representable.
    localparam logic [SEL_W:0] NUM_CACHES_X = (SEL_W+1)'(NUM_CACHES);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] pending_q, pending_d;
    logic [SEL_W-1:0] cache_sel_q, cache_sel_d;
    logic             flush_req_q, flush_req_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Next-state logic; done/err/flush_req are registered from the next state so
    // they are clean flop outputs aligned with the DONE and FLUSH cycles.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cache_sel_d = cache_sel_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.switch_cache_w) begin
                    pending_d = bus.switch_id;
                    state_d   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!bus.cache_busy) begin
                    if ({1'b0, pending_q} >= NUM_CACHES_X) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (pending_q == cache_sel_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (bus.flush_ack) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                cache_sel_d = pending_q;
                state_d     = DONE;
                done_d      = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        flush_req_d = (state_d == FLUSH);
    end

    // State and output registers with synchronous reset that aborts any switch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            cache_sel_q <= '0;
            flush_req_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cache_sel_q <= cache_sel_d;
            flush_req_q <= flush_req_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef CACHE_SWITCH_STATS_EN
    logic        switched_q, switched_d;
    logic [15:0] switch_count_q, switch_count_d;

    // Remember that SWITCH was visited so only real bank changes are counted.
    always_comb begin
        switched_d     = (state_q == SWITCH);
        switch_count_d = switch_count_q;
        if ((state_q == DONE) && switched_q && (switch_count_q != 16'hFFFF)) begin
            switch_count_d = switch_count_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            switched_q     <= 1'b0;
            switch_count_q <= '0;
        end else begin
            switched_q     <= switched_d;
            switch_count_q <= switch_count_d;
        end
    end

    assign bus.switch_count = switch_count_q;
`endif

    // Stall rises combinationally with the strobe so the instruction is frozen at once.
    assign bus.stall = ((state_q != IDLE) && (state_q != DONE)) ||
                       ((state_q == IDLE) && bus.switch_cache_w);

    assign bus.flush_req   = flush_req_q;
    assign bus.cache_sel   = cache_sel_q;
    assign bus.switch_done = done_q;
    assign bus.switch_err  = err_q;

endmodule

// File: tb/tb_cache_switch_ctrl.sv
// Testbench for cache_switch_ctrl: a directed vector table followed by randomized
// switch transactions checked against a transaction-level timing model.
// Optional macro: CACHE_SWITCH_STATS_EN also checks switch_count.
module tb_cache_switch_ctrl;

    localparam int NC = 4;
    localparam int SW = 3;

    logic CLK;
    logic RESET;

    cache_switch_ctrl_if #(.SEL_W(SW)) bus ();

    cache_switch_ctrl #(.NUM_CACHES(NC), .SEL_W(SW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          rst;
        logic          strobe;
        logic [SW-1:0] id;
        logic          busy;
        logic          ack;
        logic          chk;
        logic          stall;
        logic          flush;
        logic          done;
        logic          err;
        logic [SW-1:0] sel;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // Append one directed vector.
    function automatic void addV(input logic rst, input logic s, input int id,
                                 input logic busy, input logic ack, input logic chk,
                                 input logic st, input logic fl, input logic dn,
                                 input logic er, input int sel);
        vec_t v;
        v.rst = rst; v.strobe = s; v.id = SW'(id); v.busy = busy; v.ack = ack;
        v.chk = chk; v.stall = st; v.flush = fl; v.done = dn; v.err = er;
        v.sel = SW'(sel);
        vecs.push_back(v);
    endfunction

    task automatic checkOne(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        RESET              = v.rst;
        bus.switch_cache_w = v.strobe;
        bus.switch_id      = v.id;
        bus.cache_busy     = v.busy;
        bus.flush_ack      = v.ack;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        @(negedge CLK);
        if (v.chk) begin
            checkOne({tag, " stall"},     16'(bus.stall),       16'(v.stall));
            checkOne({tag, " flush_req"}, 16'(bus.flush_req),   16'(v.flush));
            checkOne({tag, " done"},      16'(bus.switch_done), 16'(v.done));
            checkOne({tag, " err"},       16'(bus.switch_err),  16'(v.err));
            checkOne({tag, " cache_sel"}, 16'(bus.cache_sel),   16'(v.sel));
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int   modelSel;
        int   modelCount;
        vec_t v;

        // Reset
        addV(1,0,0,0,0,0, 0,0,0,0,0);
        addV(1,0,0,0,0,1, 0,0,0,0,0);
        // Basic switch to 2, strobe held through DONE
        addV(0,1,2,0,0,1, 1,0,0,0,0);
        addV(0,1,2,0,0,1, 1,0,0,0,0);
        addV(0,1,2,0,1,1, 1,1,0,0,0);
        addV(0,1,2,0,0,1, 1,0,0,0,0);
        addV(0,1,2,0,0,1, 0,0,1,0,2);
        addV(0,0,0,0,0,1, 0,0,0,0,2);
        // Same id
        addV(0,1,2,0,0,1, 1,0,0,0,2);
        addV(0,1,2,0,0,1, 1,0,0,0,2);
        addV(0,1,2,0,0,1, 0,0,1,0,2);
        addV(0,0,0,0,0,1, 0,0,0,0,2);
        // Out-of-range id
        addV(0,1,5,0,0,1, 1,0,0,0,2);
        addV(0,1,5,0,0,1, 1,0,0,0,2);
        addV(0,1,5,0,0,1, 0,0,1,1,2);
        addV(0,0,0,0,0,1, 0,0,0,0,2);
        // Busy wait, switch to 1
        addV(0,1,1,1,0,1, 1,0,0,0,2);
        addV(0,1,1,1,0,1, 1,0,0,0,2);
        addV(0,1,1,1,0,1, 1,0,0,0,2);
        addV(0,1,1,1,0,1, 1,0,0,0,2);
        addV(0,1,1,0,0,1, 1,0,0,0,2);
        addV(0,1,1,0,1,1, 1,1,0,0,2);
        addV(0,1,1,0,0,1, 1,0,0,0,2);
        addV(0,1,1,0,0,1, 0,0,1,0,1);
        addV(0,0,0,0,0,1, 0,0,0,0,1);
        // Reset in the middle of a flush, late ack ignored
        addV(0,1,3,0,0,1, 1,0,0,0,1);
        addV(0,1,3,0,0,1, 1,0,0,0,1);
        addV(0,1,3,0,0,1, 1,1,0,0,1);
        addV(1,1,3,0,0,1, 1,1,0,0,1);
        addV(0,0,0,0,1,1, 0,0,0,0,0);
        addV(0,0,0,0,0,1, 0,0,0,0,0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("dir%0d", i));
        end

`ifdef CACHE_SWITCH_STATS_EN
        checkOne("count after reset", bus.switch_count, 16'd0);
`endif

        // Randomized transactions against a timing model derived from the phase lengths.
        modelSel   = 0;
        modelCount = 0;
        for (int t = 0; t < 60; t++) begin
            int  id;
            int  b;
            int  a;
            int  doneCyc;
            bit  real_sw;
            bit  is_err;
            id      = int'($urandom_range(0, 7));
            b       = int'($urandom_range(0, 3));
            a       = int'($urandom_range(0, 3));
            is_err  = (id >= NC);
            real_sw = !is_err && (id != modelSel);
            doneCyc = real_sw ? (b + a + 4) : (b + 2);
            for (int c = 0; c <= doneCyc + 1; c++) begin
                v.rst    = 1'b0;
                v.chk    = 1'b1;
                v.strobe = (c <= doneCyc);
                v.id     = (c == 0) ? SW'(id) : SW'($urandom);
                if (c <= b)
                    v.busy = 1'b1;
                else if (c >= b + 2)
                    v.busy = 1'($urandom);
                else
                    v.busy = 1'b0;
                v.ack    = (real_sw && c == b + 2 + a) ||
                           (c >= 1 && c <= b + 1 && $urandom_range(0, 2) == 0);
                v.stall  = (c < doneCyc);
                v.flush  = real_sw && (c >= b + 2) && (c <= b + 2 + a);
                v.done   = (c == doneCyc);
                v.err    = (c == doneCyc) && is_err;
                v.sel    = (real_sw && c >= doneCyc) ? SW'(id) : SW'(modelSel);
                applyStimulus(v);
                checkOutput(v, $sformatf("rnd%0d.c%0d", t, c));
            end
            if (real_sw) begin
                modelSel = id;
                modelCount++;
            end
`ifdef CACHE_SWITCH_STATS_EN
            checkOne($sformatf("rnd%0d count", t), bus.switch_count, 16'(modelCount));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
